// File: rtl/nios_system_sensor_in_pio.sv
// Avalon-MM input PIO for the greenhouse sensor and button lines.
// Each input bit is synchronised and debounced. Edges on the accepted level are
// captured in EDGECAPTURE, and a maskable level interrupt is raised to the CPU.
module nios_system_sensor_in_pio #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]           sync1;
  logic [WIDTH-1:0]           sync2;
  logic [WIDTH-1:0]           stable;
  logic [WIDTH-1:0]           stable_d;
  logic [WIDTH-1:0]           irq_mask;
  logic [WIDTH-1:0]           edge_capture;
  logic [WIDTH-1:0][CntW-1:0] cnt;

  logic [WIDTH-1:0]           stable_nxt;
  logic [WIDTH-1:0][CntW-1:0] cnt_nxt;
  logic [WIDTH-1:0]           edge_evt;
  logic [WIDTH-1:0]           ec_clr;
  logic [WIDTH-1:0]           ec_nxt;
  logic [31:0]                rd_mux;
  logic                       wr_en;
  logic                       unused_wdata;

  assign wr_en = chipselect & ~write_n;
  // Only the low WIDTH bits of writedata are used.
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser for the raw asynchronous inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: the synchronised level must disagree with the accepted
  // level for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CntMax) begin
        stable_nxt[i] = sync2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CntW'(1);
      end
    end
  end

  // Debounce state and the one-cycle-delayed copy used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable   <= '0;
      stable_d <= '0;
      cnt      <= '0;
    end else begin
      stable   <= stable_nxt;
      stable_d <= stable;
      cnt      <= cnt_nxt;
    end
  end

  // Edge events on the accepted level, filtered by the capture mode.
  always_comb begin
    edge_evt = '0;
    if (EDGE_TYPE == 0) begin
      edge_evt = stable & ~stable_d;
    end else if (EDGE_TYPE == 1) begin
      edge_evt = ~stable & stable_d;
    end else begin
      edge_evt = stable ^ stable_d;
    end
  end

  // Write-1-to-clear, with a new event taking priority over a clear on the same bit.
  always_comb begin
    ec_clr = '0;
    if (wr_en && (address == 2'd3)) begin
      ec_clr = writedata[WIDTH-1:0];
    end
    ec_nxt = (edge_capture & ~ec_clr) | edge_evt;
  end

  // Software-visible mask and capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && (address == 2'd2)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_capture <= ec_nxt;
    end
  end

  // Read mux. Reserved and unused upper bits read as zero.
  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  // Level interrupt, combinational from registers.
  assign irq = |(edge_capture & irq_mask);

endmodule

// File: doc/nios_system_sensor_in_pio.md
Name: nios_system_sensor_in_pio

Overview:
- Avalon-MM slave input PIO; the read-direction counterpart of the system's output PIOs.
- Samples WIDTH asynchronous greenhouse sensor/button lines, synchronises and debounces each bit, and captures edges.
- Raises a maskable interrupt to the Nios II.
- Sits on the Nios system interconnect next to the LCD/LED output PIOs.

Parameters:
- WIDTH, 8: number of input lines (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles a synchronised level must persist before acceptance (>=1).
- EDGE_TYPE, 2: capture mode; 0 = rising, 1 = falling, 2 = any edge.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt to CPU.

Behaviour:
- Register map:
  - 0 DATA: read-only, debounced levels in [WIDTH-1:0]; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2 IRQMASK: read/write [WIDTH-1:0].
  - 3 EDGECAPTURE: read; write-1-to-clear per bit.
  - Unused upper readdata bits read 0.
- Write occurs on a clk edge with chipselect=1 and write_n=0.
- Read latency is 1: readdata is registered every cycle from the address; the value at edge t reflects the address and registers before edge t.
- Synchroniser: two flops per bit (sync1, sync2).
- Debouncer, per bit: counter cnt of width clog2(DEBOUNCE_CYCLES) (min 1) and accepted level stable.
  - Each edge: if sync2 == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, stable <= sync2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Latency: in_port change set up before edge k, then stable changes at edge k+1+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles restarts cnt and never reaches stable.
- Edge detect: stable_d <= stable each edge. Event when stable != stable_d, filtered by EDGE_TYPE (rising = stable & ~stable_d). EDGECAPTURE bit sets at the edge after stable changes (k+2+DEBOUNCE_CYCLES) and holds until cleared.
- Simultaneous clear write and new event on the same bit in the same cycle: set wins, bit stays 1. Clearing other bits is unaffected.
- irq = |(EDGECAPTURE & IRQMASK), combinational from registers, no extra latency. Clearing the last pending masked bit deasserts irq the cycle after the write edge.
- Reset (any time, including mid-debounce): sync1, sync2, stable, stable_d, cnt, IRQMASK, EDGECAPTURE, readdata all 0; irq = 0.
  - An input held high through reset is accepted after release as a rising edge (captured if EDGE_TYPE allows). IRQMASK = 0 at reset, so no interrupt until software enables it.
- Bits are independent; any number may change in the same cycle.

Test Plan:
- WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_TYPE=2: in_port 0x00->0x05 before edge k -> DATA reads 0x05 from the read issued after edge k+5; EDGECAPTURE=0x05 after edge k+6; irq stays 0 (mask 0).
- Write IRQMASK=0x04, then in_port bit2 1->0 -> EDGECAPTURE bit2 set, irq=1. Write EDGECAPTURE=0x04 -> irq=0 next cycle; EDGECAPTURE reads 0x01.
- DEBOUNCE_CYCLES=4: pulse bit0 high for 3 synchronised cycles -> DATA stays 0x00, EDGECAPTURE unchanged. A 4-cycle pulse -> DATA bit0=1, then returns 0 after release plus 4 cycles.
- EDGE_TYPE=0: bit1 rising then falling -> EDGECAPTURE=0x02 only after the rise; the fall sets nothing.
- Write EDGECAPTURE=0x01 in the same cycle bit0 edge is detected -> bit0 remains 1; irq remains asserted if masked.
- Assert reset mid-debounce with EDGECAPTURE=0xFF, IRQMASK=0xFF -> all registers, readdata and irq read 0. in_port held 0x80 through release -> DATA=0x80 after 2+DEBOUNCE_CYCLES cycles, EDGECAPTURE=0x80, irq=0.
